lab4_net_input_terminal_queue: RTL and testbench
================================================

Name: lab4_net_input_terminal_queue

Overview:
- Per-router terminal input queue; sits directly upstream of the router's adaptive input terminal control.
- Buffers network messages injected by the local terminal and presents the head message to the control.
- Exposes the head message's destination field, head valid and a free-entry count.
- Dequeues when the control signals ready, which happens when the crossbar grants the head's request.

Parameters:
- p_num_entries, 4: queue depth; any value >= 2, power of two not required.
- p_msg_nbits, 44: network message width; the destination occupies the top c_dest_nbits bits.
- p_num_routers, 8: number of routers; sets the destination field width.
- c_dest_nbits, $clog2(p_num_routers): derived; not set externally.
- c_cnt_nbits, $clog2(p_num_entries+1): derived; width of counts (3 for depth 4).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- enq_val  input  1  terminal offers a message.
- enq_rdy  output  1  queue accepts a message this cycle.
- enq_msg  input  p_msg_nbits  injected message.
- deq_val  output  1  head entry is valid.
- deq_rdy  input  1  control consumes the head (the control's in_rdy).
- deq_msg  output  p_msg_nbits  head message.
- deq_dest  output  c_dest_nbits  deq_msg[p_msg_nbits-1 -: c_dest_nbits].
- num_free  output  c_cnt_nbits  p_num_entries minus occupied entries.

Behaviour:
- Storage: circular buffer of p_num_entries registers; head and tail pointers; occupancy counter.
- Pointers advance by 1 and wrap from p_num_entries-1 to 0 by explicit compare, not power-of-two masking.
- Enqueue fires when enq_val && enq_rdy. The message is written at tail on the next posedge, and tail advances.
- Dequeue fires when deq_val && deq_rdy, and head advances.
- deq_rdy while deq_val=0 is ignored: no state change and no pointer motion.
- enq_rdy = (count != p_num_entries). It depends only on registered state; there is no combinational path from deq_rdy. A full queue with a simultaneous dequeue still refuses the enqueue that cycle.
- deq_val = (count != 0). deq_msg and deq_dest are driven from the head entry. Their values are don't-care when deq_val=0, but they must not be X-propagating from uninitialised storage in simulation; storage is cleared at reset.
- num_free = p_num_entries - count, registered-state-derived, and valid in the same cycle as deq_val.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on a simultaneous enqueue and dequeue.
  - Never exceeds p_num_entries and never goes below 0.
- Latency: a message enqueued in cycle N is visible at the head in cycle N+1 at the earliest (non-bypass build).
- Ordering: strict FIFO; no reordering or drop.
- Reset (reset=0 at posedge):
  - head=0, tail=0, count=0.
  - All entries cleared to 0.
  - Outputs next cycle: enq_rdy=1, deq_val=0, deq_msg=0, deq_dest=0, num_free=p_num_entries.
  - A reset asserted mid-operation discards all contents, and any enqueue or dequeue in that cycle is ignored.
- Full/empty boundaries:
  - Full: count=p_num_entries, enq_rdy=0, num_free=0.
  - Empty: deq_val=0, num_free=p_num_entries.
  - Wrap: after the pointer reaches p_num_entries-1, the next operation uses index 0.

Optional Feature:
- Macro: LAB4_NET_INPUT_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and enq_val=1, deq_val=1 and deq_msg/deq_dest = enq_msg combinationally in the same cycle.
  - If deq_rdy=1 that cycle, the message passes through without being written. Pointers and count are unchanged.
  - If deq_rdy=0, the message is written normally.
  - num_free still reflects registered occupancy only.
- Undefined: no combinational path from the enqueue side to the dequeue side; minimum latency is 1 cycle.

Test Plan:
- Reset held 0 for 2 cycles, then released -> enq_rdy=1, deq_val=0, num_free=4, deq_dest=0.
- Enqueue 4 messages with dest 3,5,0,7 back-to-back, deq_rdy=0 -> num_free steps 3,2,1,0; enq_rdy=0 after the 4th; deq_dest=3.
- From full, deq_rdy=1 and enq_val=1 for one cycle -> enqueue refused, one dequeue, num_free=1, deq_dest=5.
- Simultaneous enq+deq for 10 cycles at count=2 -> count stays 2, FIFO order preserved, pointers wrap past index 3 correctly.
- Reset asserted with 3 entries queued -> deq_val=0 and num_free=4 next cycle; the enqueue attempted during reset is lost.
- Bypass build: empty queue, enq dest=6 with deq_rdy=1 -> deq_val=1 and deq_dest=6 same cycle, num_free stays 4; non-bypass build: deq_val=0 that cycle, deq_val=1 the next.

Source files
------------

// File: rtl/lab4_net_input_terminal_queue.sv
// Terminal input queue feeding the router's adaptive input terminal control.
// Optional same-cycle bypass when empty: define LAB4_NET_INPUT_QUEUE_BYPASS_EN.
module lab4_net_input_terminal_queue #(
   parameter  int unsigned p_num_entries = 4,
   parameter  int unsigned p_msg_nbits   = 44,
   parameter  int unsigned p_num_routers = 8,
   localparam int unsigned c_dest_nbits  = $clog2(p_num_routers),
   localparam int unsigned c_cnt_nbits   = $clog2(p_num_entries + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enq_val,
   output logic                    enq_rdy,
   input  logic [p_msg_nbits-1:0]  enq_msg,
   output logic                    deq_val,
   input  logic                    deq_rdy,
   output logic [p_msg_nbits-1:0]  deq_msg,
   output logic [c_dest_nbits-1:0] deq_dest,
   output logic [c_cnt_nbits-1:0]  num_free
);

   localparam int unsigned c_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

   logic [p_msg_nbits-1:0] mem_q [p_num_entries];
   logic [p_msg_nbits-1:0] mem_d [p_num_entries];
   logic [c_ptr_nbits-1:0] head_q, head_d;
   logic [c_ptr_nbits-1:0] tail_q, tail_d;
   logic [c_cnt_nbits-1:0] count_q, count_d;

   logic stored_val_c;
   logic write_en_c;
   logic pop_en_c;

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
      return (p == c_ptr_nbits'(p_num_entries - 1)) ? '0 : p + c_ptr_nbits'(1);
   endfunction

   assign stored_val_c = (count_q != '0);
   assign enq_rdy      = (count_q != c_cnt_nbits'(p_num_entries));
   assign num_free     = c_cnt_nbits'(p_num_entries) - count_q;
   assign pop_en_c     = stored_val_c && deq_rdy;

`ifdef LAB4_NET_INPUT_QUEUE_BYPASS_EN
   logic bypass_c;

   // Empty queue forwards the offered message straight to the head port.
   assign bypass_c   = !stored_val_c && enq_val;
   assign deq_val    = stored_val_c || bypass_c;
   assign deq_msg    = bypass_c ? enq_msg : mem_q[head_q];
   assign write_en_c = enq_val && enq_rdy && !(bypass_c && deq_rdy);
`else
   assign deq_val    = stored_val_c;
   assign deq_msg    = mem_q[head_q];
   assign write_en_c = enq_val && enq_rdy;
`endif

   assign deq_dest = deq_msg[p_msg_nbits-1 -: c_dest_nbits];

   // Next-state: storage write, pointer advance and occupancy update.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (write_en_c) begin
         mem_d[tail_q] = enq_msg;
         tail_d        = ptr_inc(tail_q);
      end
      if (pop_en_c) begin
         head_d = ptr_inc(head_q);
      end
      case ({write_en_c, pop_en_c})
         2'b10:   count_d = count_q + c_cnt_nbits'(1);
         2'b01:   count_d = count_q - c_cnt_nbits'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q   <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Occupancy must stay within the queue depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (count_q <= c_cnt_nbits'(p_num_entries))
            else $error("queue occupancy out of range");
      end
   end

endmodule

// File: tb/tb_lab4_net_input_terminal_queue.sv
// Scoreboard bench for lab4_net_input_terminal_queue (depth 4, 44-bit msgs, 8 routers).
module tb_lab4_net_input_terminal_queue;

   logic        clk;
   logic        reset;
   logic        enq_val;
   logic        enq_rdy;
   logic [43:0] enq_msg;
   logic        deq_val;
   logic        deq_rdy;
   logic [43:0] deq_msg;
   logic [2:0]  deq_dest;
   logic [2:0]  num_free;

   int n_tests = 0;
   int n_fail  = 0;
   logic [43:0] exp_q [$];

   lab4_net_input_terminal_queue dut (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (enq_val),
      .enq_rdy  (enq_rdy),
      .enq_msg  (enq_msg),
      .deq_val  (deq_val),
      .deq_rdy  (deq_rdy),
      .deq_msg  (deq_msg),
      .deq_dest (deq_dest),
      .num_free (num_free)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [43:0] mk(input logic [2:0] d, input int unsigned p);
      return {d, 41'(p)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs just after the edge; record an accepted enqueue in the scoreboard.
   task automatic drive(input logic ev, input logic [43:0] m, input logic dr);
      enq_val = ev;
      enq_msg = m;
      deq_rdy = dr;
      if (ev && enq_rdy && reset) exp_q.push_back(m);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every dequeue handshake must match the oldest accepted message.
   always @(negedge clk) begin
      if (reset && deq_val && deq_rdy) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL deq_unexpected: got 0x%0h expected no dequeue", deq_msg);
         end else begin
            logic [43:0] e;
            e = exp_q.pop_front();
            chk("deq_msg", 64'(deq_msg), 64'(e));
            chk("deq_dest", 64'(deq_dest), 64'(e[43:41]));
         end
      end
   end

   initial begin
      logic [2:0] dests [4];
      dests = '{3'd3, 3'd5, 3'd0, 3'd7};
      reset   = 1'b0;
      enq_val = 1'b0;
      enq_msg = '0;
      deq_rdy = 1'b0;

      // Reset for two cycles
      tick();
      tick();
      chk("rst_enq_rdy", 64'(enq_rdy), 64'd1);
      chk("rst_deq_val", 64'(deq_val), 64'd0);
      chk("rst_num_free", 64'(num_free), 64'd4);
      chk("rst_deq_dest", 64'(deq_dest), 64'd0);
      chk("rst_deq_msg", 64'(deq_msg), 64'd0);
      reset = 1'b1;

      // Fill to full
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk(dests[i], 32'h100 + 32'(i)), 1'b0);
         tick();
         chk("fill_num_free", 64'(num_free), 64'(3 - i));
      end
      chk("full_enq_rdy", 64'(enq_rdy), 64'd0);
      chk("full_deq_dest", 64'(deq_dest), 64'd3);
      chk("full_deq_val", 64'(deq_val), 64'd1);

      // Full with simultaneous enq+deq: enqueue refused
      drive(1'b1, mk(3'd2, 32'h999), 1'b1);
      tick();
      chk("fulldeq_num_free", 64'(num_free), 64'd1);
      chk("fulldeq_deq_dest", 64'(deq_dest), 64'd5);
      chk("fulldeq_enq_rdy", 64'(enq_rdy), 64'd1);

      drive(1'b0, '0, 1'b1);
      tick();
      chk("cnt2_num_free", 64'(num_free), 64'd2);
      chk("cnt2_deq_dest", 64'(deq_dest), 64'd0);

      // Steady-state enq+deq at count 2; pointers wrap several times
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, mk(3'(i), 32'h200 + 32'(i)), 1'b1);
         tick();
         chk("steady_num_free", 64'(num_free), 64'd2);
      end

      drive(1'b1, mk(3'd4, 32'h300), 1'b0);
      tick();
      chk("cnt3_num_free", 64'(num_free), 64'd1);

      // Reset mid-operation with an enqueue attempt that must be lost
      reset = 1'b0;
      drive(1'b1, mk(3'd6, 32'h400), 1'b1);
      exp_q.delete();
      tick();
      reset = 1'b1;
      drive(1'b0, '0, 1'b0);
      chk("midrst_deq_val", 64'(deq_val), 64'd0);
      chk("midrst_num_free", 64'(num_free), 64'd4);
      chk("midrst_enq_rdy", 64'(enq_rdy), 64'd1);
      tick();
      chk("midrst_lost_num_free", 64'(num_free), 64'd4);

      // deq_rdy on an empty queue is ignored
      drive(1'b0, '0, 1'b1);
      tick();
      chk("emptydeq_num_free", 64'(num_free), 64'd4);
      chk("emptydeq_deq_val", 64'(deq_val), 64'd0);

      // Empty queue, enqueue with deq_rdy=1: bypass vs one-cycle latency
      drive(1'b1, mk(3'd6, 32'h55), 1'b1);
      #1;
`ifdef LAB4_NET_INPUT_QUEUE_BYPASS_EN
      chk("byp_deq_val", 64'(deq_val), 64'd1);
      chk("byp_deq_dest", 64'(deq_dest), 64'd6);
      chk("byp_num_free", 64'(num_free), 64'd4);
      tick();
      chk("byp_after_deq_val", 64'(deq_val), 64'd0);
      chk("byp_after_num_free", 64'(num_free), 64'd4);
      drive(1'b0, '0, 1'b1);
`else
      chk("lat_deq_val_same", 64'(deq_val), 64'd0);
      chk("lat_num_free_same", 64'(num_free), 64'd4);
      tick();
      chk("lat_deq_val_next", 64'(deq_val), 64'd1);
      chk("lat_deq_dest_next", 64'(deq_dest), 64'd6);
      chk("lat_num_free_next", 64'(num_free), 64'd3);
      drive(1'b0, '0, 1'b1);
`endif
      tick();
      chk("lat_drained_num_free", 64'(num_free), 64'd4);

      // Burst of three then drain, checking order through the scoreboard
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(3'(7 - i), 32'h600 + 32'(i)), 1'b0);
         tick();
      end
      chk("burst_num_free", 64'(num_free), 64'd1);
      drive(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      chk("drain_deq_val", 64'(deq_val), 64'd0);
      chk("drain_num_free", 64'(num_free), 64'd4);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
